// File: rtl/l2_prefetch_pkg.sv
// Shared types and constants for the L2 prefetch fill engine.
// Holds the FSM state type, buffer geometry and the line-base helper.
package l2_prefetch_pkg;

  localparam int INDEX_W = 7;
  localparam int ENTRIES = 128;
  localparam int ADDR_W  = 26;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_REQ   = 2'd2,
    ST_FILL  = 2'd3
  } state_e;

  // Clears the word-offset bits so the address points at its line start.
  function automatic logic [ADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] a,
    input int unsigned       words
  );
    logic [ADDR_W-1:0] m;
    m = ADDR_W'(words - 1);
    return a & ~m;
  endfunction

endpackage

// File: rtl/l2_prefetch_fill_skid.sv
// prefetch_skid: 2-entry FIFO of {addr, data} holding displaced fill beats.
// Ports: clk, rst (sync high), push/pop/flush in, in_a/in_d, out_a/out_d, empty/full.
module prefetch_skid #(
  parameter int AW = 26,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] in_a,
  input  logic [DW-1:0] in_d,
  output logic [AW-1:0] out_a,
  output logic [DW-1:0] out_d,
  output logic          empty,
  output logic          full
);

  logic [AW+DW-1:0] e0_q, e0_d;
  logic [AW+DW-1:0] e1_q, e1_d;
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign {out_a, out_d} = rp_q ? e1_q : e0_q;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = 1'b0;
      rp_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) begin
        if (wp_q) e1_d = {in_a, in_d};
        else      e0_d = {in_a, in_d};
        wp_d = ~wp_q;
      end
      if (do_pop) rp_d = ~rp_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_prefetch_fill.sv
// l2_prefetch_fill: burst fill, CPU write forwarding and flush for the L2
// prefetch buffer. Ports: CLK/RST, Miss*, Flush, Busy, Mem* burst side,
// CPUWR* forward side, WRA/WRD/WR/WRM/CLR buffer side (all registered).
// Macro PREFETCH_NEXTLINE_EN: fetch the line after the miss, not the miss line.
module l2_prefetch_fill
  import l2_prefetch_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MissValid,
  input  logic [25:0] MissA,
  input  logic        Flush,
  output logic        Busy,
  output logic        MemReq,
  output logic [25:0] MemA,
  input  logic        MemAck,
  input  logic        MemDValid,
  input  logic [31:0] MemD,
  input  logic        CPUWR,
  input  logic [25:0] CPUWRA,
  input  logic [31:0] CPUWRD,
  input  logic [3:0]  CPUWRM,
  output logic [25:0] WRA,
  output logic [31:0] WRD,
  output logic        WR,
  output logic [3:0]  WRM,
  output logic        CLR
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [CW-1:0] LW_C = CW'(LINE_WORDS);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

`ifdef PREFETCH_NEXTLINE_EN
  localparam logic [ADDR_W-1:0] NL_OFS = ADDR_W'(LINE_WORDS);
`else
  localparam logic [ADDR_W-1:0] NL_OFS = '0;
`endif

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:0]   mema_q, mema_d;
  logic                abort_q, abort_d;
  logic                pend_q, pend_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   wra_q, wra_d;
  logic [31:0]         wrd_q, wrd_d;
  logic [3:0]          wrm_q, wrm_d;
  logic                clr_q, clr_d;

  logic                skid_push, skid_pop, skid_flush;
  logic                skid_empty, skid_full;
  logic [ADDR_W-1:0]   skid_a;
  logic [31:0]         skid_d;

  logic                active, cpu_fwd, cpu_hit, flush_hit;
  logic                abort_now, fill_beat, keep_beat;
  logic [ADDR_W-1:0]   beat_addr;
  logic [CW-1:0]       beat_nx;
  logic                skid_drains;

  assign active    = (state_q == ST_REQ) | (state_q == ST_FILL);
  assign cpu_fwd   = CPUWR & (state_q != ST_FLUSH);
  assign cpu_hit   = active & CPUWR &
                     (line_base(CPUWRA, LINE_WORDS) == mema_q);
  assign flush_hit = active & Flush;
  // Abort takes effect on the beat coincident with its cause.
  assign abort_now = abort_q | cpu_hit | flush_hit;
  assign fill_beat = (state_q == ST_FILL) & MemDValid & (beat_q != LW_C);
  assign keep_beat = fill_beat & ~abort_now;
  assign beat_addr = mema_q + ADDR_W'(beat_q);
  assign beat_nx   = beat_q + CW'(fill_beat);

  prefetch_skid #(.AW(ADDR_W), .DW(32)) u_skid (
    .clk   (CLK),
    .rst   (RST),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (skid_flush),
    .in_a  (beat_addr),
    .in_d  (MemD),
    .out_a (skid_a),
    .out_d (skid_d),
    .empty (skid_empty),
    .full  (skid_full)
  );

  // Buffer write port arbitration: clear > CPU > oldest skid > live beat.
  always_comb begin
    wr_d  = 1'b0;
    wra_d = '0;
    wrd_d = '0;
    wrm_d = '0;
    clr_d = 1'b0;
    skid_pop   = 1'b0;
    skid_push  = 1'b0;
    skid_flush = abort_now;
    if (state_q == ST_FLUSH) begin
      wr_d  = 1'b1;
      wra_d = ADDR_W'(idx_q);
      wrm_d = 4'hF;
      clr_d = 1'b1;
    end else if (cpu_fwd) begin
      wr_d  = 1'b1;
      wra_d = CPUWRA;
      wrd_d = CPUWRD;
      wrm_d = CPUWRM;
    end else if (~skid_empty & ~abort_now) begin
      wr_d  = 1'b1;
      wra_d = skid_a;
      wrd_d = skid_d;
      wrm_d = 4'hF;
      skid_pop = 1'b1;
    end else if (keep_beat) begin
      wr_d  = 1'b1;
      wra_d = beat_addr;
      wrd_d = MemD;
      wrm_d = 4'hF;
    end
    // Beats must stay in order, so one queues behind any skid content.
    skid_push = keep_beat & (cpu_fwd | ~skid_empty);
  end

  assign skid_drains = abort_now |
                       (skid_empty & ~skid_push) |
                       (~skid_empty & ~skid_full & skid_pop & ~skid_push);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    mema_d  = mema_q;
    abort_d = abort_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_FLUSH: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (Flush) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else if (MissValid) begin
          state_d = ST_REQ;
          mema_d  = line_base(MissA, LINE_WORDS) + NL_OFS;
          beat_d  = '0;
          abort_d = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_REQ: begin
        abort_d = abort_now;
        pend_d  = pend_q | Flush;
        if (MemAck) begin
          state_d = ST_FILL;
          beat_d  = '0;
        end
      end
      ST_FILL: begin
        abort_d = abort_now;
        pend_d  = pend_q | Flush;
        beat_d  = beat_nx;
        if ((beat_nx == LW_C) & skid_drains) begin
          state_d = (pend_q | Flush) ? ST_FLUSH : ST_IDLE;
          idx_d   = '0;
          abort_d = 1'b0;
          pend_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FLUSH;
      idx_q   <= '0;
      beat_q  <= '0;
      mema_q  <= '0;
      abort_q <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      wra_q   <= '0;
      wrd_q   <= '0;
      wrm_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      mema_q  <= mema_d;
      abort_q <= abort_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      wra_q   <= wra_d;
      wrd_q   <= wrd_d;
      wrm_q   <= wrm_d;
      clr_q   <= clr_d;
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign MemReq = (state_q == ST_REQ);
  assign MemA   = mema_q;
  assign WR     = wr_q;
  assign WRA    = wra_q;
  assign WRD    = wrd_q;
  assign WRM    = wrm_q;
  assign CLR    = clr_q;

endmodule
